uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- 8N1 UART receive engine for uart_receiver2. It sits directly downstream of the power-on reset delay stage.
- The delay stage's reset output drives this block's reset input, so reception starts only after the settle interval has elapsed.
- The block synchronises the asynchronous RXD pin, validates the start bit, and samples 8 data bits LSB-first at mid-bit.
- Each received byte is presented with a one-cycle valid strobe, or a one-cycle framing-error strobe if the stop bit is bad.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud). Legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter. Must hold CLKS_PER_BIT-1.

Ports:
- urx_i_clock  input  1  system clock. All logic is on the rising edge.
- urx_i_reset_n  input  1  asynchronous active-low reset, driven by the reset delay stage output.
- urx_i_rxd  input  1  serial line, asynchronous to the clock, idle high.
- urx_o_data  output  8  last correctly framed byte. Holds its value until the next good frame.
- urx_o_valid  output  1  one-cycle pulse: urx_o_data was updated this cycle.
- urx_o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- urx_o_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low, no clock needed):
  - Both synchroniser flops go to 1.
  - State goes to IDLE; bit counter and bit index go to 0; shift register goes to 0.
  - All outputs go to 0.
  - Release is synchronous to the first clock edge with reset_n high.
- Synchroniser:
  - Two flops, s1 <= rxd and s2 <= s1. The FSM uses only s2.
  - Pin-to-s2 latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - busy = 0.
  - On s2 == 0: go to START, counter = 0.
- START:
  - Counter increments each cycle.
  - When counter == CLKS_PER_BIT/2 - 1 (integer division), sample s2:
    - s2 == 0: go to DATA, counter = 0, index = 0.
    - s2 == 1: glitch. Return to IDLE with no strobe.
- DATA:
  - Counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample s2 into shift[index] (LSB first) and reset the counter to 0.
  - After index 7 is sampled, go to STOP; otherwise index increments.
- STOP:
  - At counter == CLKS_PER_BIT-1, sample s2:
    - s2 == 1: in the same cycle, latch shift into urx_o_data, pulse urx_o_valid for exactly 1 cycle, go to IDLE.
    - s2 == 0: pulse urx_o_frame_err for 1 cycle, leave urx_o_data unchanged, go to BREAK.
- BREAK:
  - busy stays 1.
  - Wait until s2 == 1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err and no phantom frames.
- Back-to-back frames:
  - Return to IDLE occurs at the stop-bit midpoint.
  - A start edge half a bit later is detected normally. No idle gap beyond the stop bit is required.
- Timing:
  - urx_o_valid asserts CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after IDLE first sees s2 == 0, within 1 cycle. Add 2 cycles for the synchroniser from the pin edge.
- Strobes: valid and frame_err are never high in the same cycle. Both are registered outputs.
- Reset mid-frame: the frame is aborted, no strobe is issued, and urx_o_data returns to 0.
- Widths: the counter is CNT_W bits, compared against CLKS_PER_BIT-1 truncated to CNT_W bits. No wrap occurs in legal configurations.

Test Plan:
- Hold reset 5 cycles then release, line idle high → data = 0x00, valid = 0, busy = 0 for 100 cycles.
- CLKS_PER_BIT = 16, send 0xA5 then 0x3C back-to-back with one stop bit each → two valid pulses exactly 160 cycles apart, data = 0xA5 then 0x3C, frame_err never asserts.
- CLKS_PER_BIT = 16, 5-cycle low glitch on idle line → FSM returns to IDLE, no valid or frame_err pulse, busy high for about 8 cycles only.
- Send 0x55 with stop bit low, then hold line low for 40 bit times, then release → exactly one frame_err pulse, data keeps its previous value, busy drops only after the line returns high, and the next 0x81 frame is received correctly.
- Assert reset during bit 4 of 0xFF, release, then send 0x12 → no strobe from the aborted frame, data = 0x00 until 0x12 is received cleanly with one valid pulse.
- CLKS_PER_BIT = 434 at nominal rate, and again with sender ±2% baud skew, send 0x00 and 0xFF → both bytes received correctly, each with a single valid pulse.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: two-flop RXD synchroniser, mid-bit sampling, LSB-first data,
// one-cycle valid or framing-error strobe per frame, and a break state that waits for idle.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       urx_i_clock,
  input  logic       urx_i_reset_n,
  input  logic       urx_i_rxd,
  output logic [7:0] urx_o_data,
  output logic       urx_o_valid,
  output logic       urx_o_frame_err,
  output logic       urx_o_busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge urx_i_clock or negedge urx_i_reset_n) begin
    if (!urx_i_reset_n) begin
      // Synchroniser resets to the idle line level so release never looks like a start bit
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      s1_q    <= urx_i_rxd;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!s2_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is gone by mid-bit was a glitch
          state_d = s2_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d          = '0;
          shift_d[idx_q] = s2_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (s2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBreak: begin
        if (s2_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    urx_o_data      = data_q;
    urx_o_valid     = valid_q;
    urx_o_frame_err = ferr_q;
    urx_o_busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a frame-level model predicts strobe times, data and busy windows from
// what the sender drove; a fast instance takes random traffic, a 434-clock instance takes skew tests.
module tb_uart_rx_core;

  localparam int A_CPB = 16;
  localparam int B_CPB = 434;

  typedef struct {
    int         t;
    bit         err;
    logic [7:0] d;
  } ev_t;

  typedef struct {
    int lo;
    int hi;
  } iv_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       rxd_a, rxd_b;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_ferr, a_busy;
  logic       b_valid, b_ferr, b_busy;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         vcount = 0, fcount = 0, busy_cycles = 0;
  int         last_vt = 0, prev_vt = 0, last_p = 0;
  int         b_vcount = 0, b_fcount = 0;
  logic [7:0] b_last = 8'h00;
  logic [7:0] model_data = 8'h00;
  ev_t        exp_q[$];
  iv_t        iv_q[$];

  uart_rx_core #(.CLKS_PER_BIT(A_CPB), .CNT_W(16)) u_dut_a (
    .urx_i_clock    (clk),
    .urx_i_reset_n  (rst_a),
    .urx_i_rxd      (rxd_a),
    .urx_o_data     (a_data),
    .urx_o_valid    (a_valid),
    .urx_o_frame_err(a_ferr),
    .urx_o_busy     (a_busy)
  );

  uart_rx_core #(.CLKS_PER_BIT(B_CPB), .CNT_W(16)) u_dut_b (
    .urx_i_clock    (clk),
    .urx_i_reset_n  (rst_b),
    .urx_i_rxd      (rxd_b),
    .urx_o_data     (b_data),
    .urx_o_valid    (b_valid),
    .urx_o_frame_err(b_ferr),
    .urx_o_busy     (b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit busy_at(input int c);
    foreach (iv_q[i]) if (c >= iv_q[i].lo && c <= iv_q[i].hi) return 1'b1;
    return 1'b0;
  endfunction

  // Frame starting on posedge p: line is seen low by the receiver 2 cycles later, the stop
  // strobe lands half a bit plus nine bits after that, one cycle after the deciding edge.
  function automatic void model_frame(input int p, input logic [7:0] b, input bit ok,
                                      input int hold);
    ev_t e;
    iv_t iv;
    e.t   = p + 2 + A_CPB / 2 + 9 * A_CPB;
    e.err = !ok;
    e.d   = b;
    exp_q.push_back(e);
    iv.lo = p + 2;
    iv.hi = ok ? e.t - 1 : p + 10 * A_CPB + hold + 1;
    iv_q.push_back(iv);
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else rxd_a = v;
  endtask

  // Called at a negedge; returns at the negedge where the stop bit (or break) ends.
  task automatic send_frame(input bit sel, input logic [7:0] b, input bit stop_ok,
                            input real cpb, input int hold_low);
    logic [9:0] bits;
    int         p;
    int         nxt;
    bits = {stop_ok, b, 1'b0};
    p    = cyc + 1;
    if (!sel) begin
      last_p = p;
      model_frame(p, b, stop_ok, hold_low);
    end
    for (int k = 0; k < 10; k++) begin
      drive(sel, bits[k]);
      nxt = p + $rtoi(cpb * real'(k + 1) + 0.5);
      while (cyc + 1 < nxt) @(negedge clk);
    end
    if (!stop_ok) begin
      repeat (hold_low) @(negedge clk);
      drive(sel, 1'b1);
    end
  endtask

  task automatic send_glitch(input int len);
    iv_t iv;
    iv.lo = cyc + 3;
    iv.hi = cyc + 2 + A_CPB / 2;
    iv_q.push_back(iv);
    drive(1'b0, 1'b0);
    repeat (len) @(negedge clk);
    drive(1'b0, 1'b1);
    repeat (A_CPB) @(negedge clk);
  endtask

  // Compare process for the fast instance
  always @(negedge clk) begin
    ev_t e;
    bit  b0, b1, b2;
    if (!rst_a) begin
      exp_q.delete();
      iv_q.delete();
      model_data = 8'h00;
      chk("reset_outputs", {a_data, a_valid, a_ferr, a_busy}, 0);
    end else begin
      if (a_valid) begin
        vcount++;
        prev_vt = last_vt;
        last_vt = cyc;
      end
      if (a_ferr) fcount++;
      if (a_busy) busy_cycles++;
      if (a_valid || a_ferr) begin
        chk("strobe_exclusive", a_valid && a_ferr, 0);
        chk("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("strobe_kind_ferr", a_ferr, e.err);
          chk("strobe_time_ok", (cyc >= e.t - 1) && (cyc <= e.t + 1), 1);
          if (!e.err) begin
            chk("valid_data", a_data, e.d);
            model_data = e.d;
          end else begin
            chk("ferr_data_kept", a_data, model_data);
          end
        end
      end else begin
        chk("data_hold", a_data, model_data);
        if (exp_q.size() != 0) begin
          chk("strobe_not_late", cyc <= exp_q[0].t + 1, 1);
          if (cyc > exp_q[0].t + 1) void'(exp_q.pop_front());
        end
      end
      b0 = busy_at(cyc - 1);
      b1 = busy_at(cyc);
      b2 = busy_at(cyc + 1);
      if (b0 == b1 && b1 == b2) chk("busy", a_busy, b1);
      while (iv_q.size() != 0 && iv_q[0].hi < cyc - 3) void'(iv_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b_valid) begin
      b_vcount++;
      b_last = b_data;
    end
    if (b_ferr) b_fcount++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int         v0, f0, bc0;
    logic [7:0] b;
    bit         ok;
    int         hold, gap;
    real        rates[3];
    logic [7:0] bb[2];
    rates = '{434.0, 434.0 / 1.02, 434.0 / 0.98};
    bb    = '{8'h00, 8'hFF};

    rst_a = 1'b0;
    rst_b = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Idle line after reset
    repeat (100) @(negedge clk);
    chk("idle_data", a_data, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_strobes", vcount + fcount, 0);

    // Back-to-back A5, 3C
    v0 = vcount;
    f0 = fcount;
    send_frame(1'b0, 8'hA5, 1'b1, 16.0, 0);
    v0 = v0 + 0;
    begin
      int p1;
      p1 = last_p;
      send_frame(1'b0, 8'h3C, 1'b1, 16.0, 0);
      repeat (20) @(negedge clk);
      chk("b2b_latency", prev_vt - p1, 154);
    end
    chk("b2b_spacing", last_vt - prev_vt, 160);
    chk("b2b_valid_count", vcount - v0, 2);
    chk("b2b_last_data", a_data, 8'h3C);
    chk("b2b_no_ferr", fcount - f0, 0);

    // Five-cycle glitch
    v0  = vcount;
    f0  = fcount;
    bc0 = busy_cycles;
    send_glitch(5);
    chk("glitch_busy_cycles", busy_cycles - bc0, 8);
    chk("glitch_no_strobe", (vcount - v0) + (fcount - f0), 0);

    // Bad stop bit then a 40-bit break, then a clean 0x81
    f0 = fcount;
    v0 = vcount;
    send_frame(1'b0, 8'h55, 1'b0, 16.0, 40 * A_CPB);
    repeat (20) @(negedge clk);
    chk("break_ferr_count", fcount - f0, 1);
    chk("break_no_valid", vcount - v0, 0);
    chk("break_data_kept", a_data, 8'h3C);
    send_frame(1'b0, 8'h81, 1'b1, 16.0, 0);
    repeat (20) @(negedge clk);
    chk("after_break_data", a_data, 8'h81);
    chk("after_break_valid", vcount - v0, 1);

    // Reset in the middle of bit 4 of 0xFF, then 0x12
    v0 = vcount;
    fork
      send_frame(1'b0, 8'hFF, 1'b1, 16.0, 0);
      begin
        repeat (5 * A_CPB + 8) @(negedge clk);
        #2 rst_a = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    chk("abort_no_strobe", vcount - v0, 0);
    chk("abort_data", a_data, 0);
    send_frame(1'b0, 8'h12, 1'b1, 16.0, 0);
    repeat (20) @(negedge clk);
    chk("abort_next_data", a_data, 8'h12);
    chk("abort_next_valid", vcount - v0, 1);

    // Random traffic with occasional glitches and bad stop bits
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 0) send_glitch(int'($urandom_range(1, 7)));
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      hold = int'($urandom_range(0, 100));
      send_frame(1'b0, b, ok, 16.0, hold);
      gap = ok ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      repeat (gap) @(negedge clk);
    end
    repeat (200) @(negedge clk);
    chk("pending_events", exp_q.size(), 0);

    // Full-rate instance, nominal and +/-2% sender skew
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        v0 = b_vcount;
        send_frame(1'b1, bb[i], 1'b1, rates[r], 0);
        repeat (60) @(negedge clk);
        chk("b_valid_count", b_vcount - v0, 1);
        chk("b_data", b_last, bb[i]);
      end
    end
    chk("b_no_ferr", b_fcount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
